// File: rtl/sopc_pio_in_capture.sv
// -----------------------------------------------------------------------------
// sopc_pio_in_capture
//
// Avalon-MM input PIO slave with an input synchroniser, per-bit edge detection
// into a sticky write-1-to-clear capture register, a per-bit interrupt mask and
// a registered level interrupt.
//
// Register map (word addresses, unused upper bits read 0):
//   0 : data          RO   filtered synchronised input
//   1 : reserved      RO   reads 0, writes ignored
//   2 : irqmask       RW   DATA_WIDTH bits
//   3 : edge_capture  RO   write 1 to a bit to clear it
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     Avalon word address
//   chipselect  Avalon slave select
//   write_n     Avalon write strobe, active low
//   writedata   Avalon write data
//   readdata    Avalon read data, registered (read latency 1)
//   in_port     asynchronous input lines
//   irq         level interrupt request, registered
//
// Optional feature macro: PIO_IN_DEBOUNCE_EN
//   When defined, each bit passes through a stability filter of
//   DEBOUNCE_CYCLES clocks after the synchroniser. When undefined the filter is
//   not built and DEBOUNCE_CYCLES has no effect.
// -----------------------------------------------------------------------------
module sopc_pio_in_capture #(
  parameter int DATA_WIDTH      = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  // Edge detection is held off until the synchroniser (and prev) hold real
  // samples, so lines already high at reset do not look like rising edges.
  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      EDGE_TYPE < 0 || EDGE_TYPE > 2 || DEBOUNCE_CYCLES < 0) begin : g_param_check
    $error("sopc_pio_in_capture: parameter out of range");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_out;

  // NOTE: every flop in this block, the synchroniser array included, is
  // cleared by reset; none of it is a RAM, so resetting it is free and keeps
  // the first post-reset samples deterministic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage take the previous
      // stage's old value, forming a true shift chain regardless of order.
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Optional stability filter
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] filtered;

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0]       db_cnt_q [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] filt_q;

  // A bit's counter runs only while the synchronised value disagrees with the
  // filtered value; any return to agreement (a glitch ending) restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int b = 0; b < DATA_WIDTH; b++) db_cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < DATA_WIDTH; b++) begin
        if (sync_out[b] == filt_q[b]) begin
          db_cnt_q[b] <= '0;
        end else if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES)) begin
          filt_q[b]   <= sync_out[b];
          db_cnt_q[b] <= '0;
        end else begin
          db_cnt_q[b] <= db_cnt_q[b] + DB_W'(1);
        end
      end
    end
  end

  assign filtered = filt_q;
`else
  assign filtered = sync_out;
`endif

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] rise, fall, edge_det;

  assign rise = filtered & ~prev_q;
  assign fall = ~filtered & prev_q;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // edge_det unassigned, which would otherwise infer a latch.
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = rise;
      1:       edge_det = fall;
      default: edge_det = rise | fall;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus decode and register next-state
  // ---------------------------------------------------------------------------
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  unused_wdata;
  logic [ARM_W-1:0]      arm_cnt_q;
  logic                  armed;
  logic [DATA_WIDTH-1:0] cap_q, cap_d, clr;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  irq_q;

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[DATA_WIDTH-1:0];
  // Write-data bits above DATA_WIDTH have no destination.
  assign unused_wdata = ^writedata;

  assign armed = (arm_cnt_q == ARM_W'(ARM_CYCLES));

  // Clear first, then OR in new events: a set on the same edge as a
  // write-1-to-clear wins, so no event is lost.
  assign clr    = (wr_en && address == 2'd3) ? wdata : '0;
  assign cap_d  = (cap_q & ~clr) | (armed ? edge_det : '0);
  assign mask_d = (wr_en && address == 2'd2) ? wdata : mask_q;

  // Read mux is sampled every clock; there is no read strobe.
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[DATA_WIDTH-1:0] = filtered;
      2'd2:    readdata_d[DATA_WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[DATA_WIDTH-1:0] = cap_q;
      default: readdata_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      arm_cnt_q  <= '0;
      cap_q      <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= filtered;
      if (!armed) arm_cnt_q <= arm_cnt_q + ARM_W'(1);
      cap_q      <= cap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      // Built from registered capture and mask, so irq follows a capture or a
      // mask change by exactly one edge.
      irq_q      <= |(cap_q & mask_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sopc_pio_in_capture.sv
// -----------------------------------------------------------------------------
// tb_sopc_pio_in_capture
//
// Directed bench for sopc_pio_in_capture. Two instances share the Avalon bus
// and reset: u_dut with default width / rising-edge detection and u_dut8 with
// DATA_WIDTH=8 / any-edge detection. Both use DEBOUNCE_CYCLES=8 so that a
// build with PIO_IN_DEBOUNCE_EN simply adds a fixed latency of 9 edges.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sopc_pio_in_capture;

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd1, rd2;
  logic        irq1, irq2;
  logic [31:0] in1;
  logic [7:0]  in2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sopc_pio_in_capture #(
    .DATA_WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1),
    .in_port(in1), .irq(irq1)
  );

  sopc_pio_in_capture #(
    .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8)
  ) u_dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2),
    .in_port(in2), .irq(irq2)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one write cycle; returns at the falling edge after the write edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // Presents an address and returns readdata of both instances one edge later.
  task automatic bus_read(input logic [1:0] a, output logic [31:0] v1,
                          output logic [31:0] v2);
    address = a;
    @(negedge clk);
    v1 = rd1;
    v2 = rd2;
  endtask

  task automatic test_reset();
    logic [31:0] v1, v2;
    in1 = 32'hFFFF_FFFF;
    in2 = 8'h00;
    reset_n = 1'b0;
    tick(3);
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq1); end
    total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL reset_readdata: got %h want 0", rd1); end
    reset_n = 1'b1;
    tick(10 + ((LAT > 0) ? LAT + 3 : 0));
    bus_read(2'd3, v1, v2);
    // With the filter, the lines rise after the arm window and are captured.
    total++; if (v1 !== ((LAT > 0) ? 32'hFFFF_FFFF : 32'h0)) begin bad++; $display("FAIL reset_no_spurious_capture: got %h", v1); end
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL reset_irq_after: got %b want 0", irq1); end
    bus_read(2'd0, v1, v2);
    total++; if (v1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_data_read: got %h want ffffffff", v1); end
    bus_read(2'd1, v1, v2);
    total++; if (v1 !== 32'h0) begin bad++; $display("FAIL reserved_read: got %h want 0", v1); end
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, v1, v2);
    total++; if (v1 !== 32'h0) begin bad++; $display("FAIL reserved_write_ignored: got %h want 0", v1); end
    bus_write(2'd3, 32'hFFFF_FFFF);
    in1 = 32'h0;
    tick(5 + LAT);
    bus_read(2'd3, v1, v2);
    total++; if (v1 !== 32'h0) begin bad++; $display("FAIL clear_and_no_fall_capture: got %h want 0", v1); end
  endtask

  task automatic test_rise_irq();
    logic [31:0] v1, v2;
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, v1, v2);
    total++; if (v1 !== 32'h1) begin bad++; $display("FAIL mask_readback: got %h want 1", v1); end
    address = 2'd3;
    in1[0]  = 1'b1;
    tick(3 + LAT);
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL irq_not_early: got %b want 0", irq1); end
    tick(1);
    total++; if (irq1 !== 1'b1) begin bad++; $display("FAIL irq_latency: got %b want 1", irq1); end
    total++; if (rd1 !== 32'h1) begin bad++; $display("FAIL capture_bit0: got %h want 1", rd1); end
    bus_write(2'd3, 32'h1);
    total++; if (irq1 !== 1'b1) begin bad++; $display("FAIL irq_hold_on_clear_edge: got %b want 1", irq1); end
    tick(1);
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq1); end
    in1[0] = 1'b0;
    tick(5 + LAT);
    bus_read(2'd3, v1, v2);
    total++; if (v1 !== 32'h0) begin bad++; $display("FAIL no_falling_capture: got %h want 0", v1); end
  endtask

  task automatic test_set_clear_collision();
    logic [31:0] v1, v2;
    in1[5] = 1'b1;
    tick(2 + LAT);
    // The write edge coincides with the edge on which bit 5 is captured.
    bus_write(2'd3, 32'h20);
    bus_read(2'd3, v1, v2);
    total++; if (v1 !== 32'h20) begin bad++; $display("FAIL set_beats_clear: got %h want 20", v1); end
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL masked_bit5_irq: got %b want 0", irq1); end
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, v1, v2);
    total++; if (v1 !== 32'h20) begin bad++; $display("FAIL write_zero_no_effect: got %h want 20", v1); end
    bus_write(2'd3, 32'h20);
    bus_read(2'd3, v1, v2);
    total++; if (v1 !== 32'h0) begin bad++; $display("FAIL w1c_bit5: got %h want 0", v1); end
  endtask

  task automatic test_mask();
    logic [31:0] v1, v2;
    bus_write(2'd2, 32'h0);
    in1[3] = 1'b1;
    tick(5 + LAT);
    bus_read(2'd3, v1, v2);
    total++; if (v1 !== 32'h8) begin bad++; $display("FAIL masked_capture: got %h want 8", v1); end
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL masked_irq: got %b want 0", irq1); end
    bus_write(2'd2, 32'h8);
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL unmask_not_early: got %b want 0", irq1); end
    tick(1);
    total++; if (irq1 !== 1'b1) begin bad++; $display("FAIL unmask_irq: got %b want 1", irq1); end
    bus_write(2'd3, 32'h8);
    bus_write(2'd2, 32'h0);
  endtask

  task automatic test_any_edge_narrow();
    logic [31:0] v1, v2;
    in2[7] = 1'b1;
    tick(5 + LAT);
    bus_read(2'd3, v1, v2);
    total++; if (v2 !== 32'h80) begin bad++; $display("FAIL any_edge_rise: got %h want 80", v2); end
    bus_write(2'd3, 32'h80);
    bus_read(2'd3, v1, v2);
    total++; if (v2 !== 32'h0) begin bad++; $display("FAIL any_edge_clear: got %h want 0", v2); end
    in2[7] = 1'b0;
    tick(5 + LAT);
    bus_read(2'd3, v1, v2);
    total++; if (v2 !== 32'h80) begin bad++; $display("FAIL any_edge_fall: got %h want 80", v2); end
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'hFFFF_FF00);
    bus_read(2'd2, v1, v2);
    total++; if (v2 !== 32'h0) begin bad++; $display("FAIL narrow_mask_upper_ignored: got %h want 0", v2); end
    bus_write(2'd2, 32'h0000_01FF);
    bus_read(2'd2, v1, v2);
    total++; if (v2 !== 32'hFF) begin bad++; $display("FAIL narrow_mask_width: got %h want ff", v2); end
    in2 = 8'h5A;
    tick(5 + LAT);
    bus_read(2'd0, v1, v2);
    total++; if (v2 !== 32'h5A) begin bad++; $display("FAIL narrow_data_read: got %h want 5a", v2); end
    total++; if (irq2 !== 1'b1) begin bad++; $display("FAIL narrow_irq: got %b want 1", irq2); end
    bus_read(2'd3, v1, v2);
    total++; if (v2 !== 32'h5A) begin bad++; $display("FAIL narrow_multi_capture: got %h want 5a", v2); end
  endtask

`ifdef PIO_IN_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] v1, v2;
    bus_write(2'd2, 32'h0);
    in1 = 32'h0;
    tick(LAT + 5);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in1[0] = 1'b1;
    tick(5);
    in1[0] = 1'b0;
    tick(20);
    bus_read(2'd3, v1, v2);
    total++; if (v1 !== 32'h0) begin bad++; $display("FAIL glitch_capture: got %h want 0", v1); end
    bus_read(2'd0, v1, v2);
    total++; if (v1 !== 32'h0) begin bad++; $display("FAIL glitch_data: got %h want 0", v1); end
    address = 2'd0;
    in1[0]  = 1'b1;
    tick(11);
    total++; if (rd1[0] !== 1'b0) begin bad++; $display("FAIL debounce_not_early: got %b want 0", rd1[0]); end
    tick(1);
    total++; if (rd1[0] !== 1'b1) begin bad++; $display("FAIL debounce_data: got %b want 1", rd1[0]); end
    tick(8);
    bus_read(2'd3, v1, v2);
    total++; if (v1 !== 32'h1) begin bad++; $display("FAIL debounce_capture: got %h want 1", v1); end
  endtask
`endif

  task automatic test_mid_reset();
    logic [31:0] v1, v2;
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'h1);
    in1 = 32'h0;
    tick(5 + LAT);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in1 = 32'h1;
    tick(5 + LAT);
    total++; if (irq1 !== 1'b1) begin bad++; $display("FAIL pre_reset_irq: got %b want 1", irq1); end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL async_reset_irq: got %b want 0", irq1); end
    total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL async_reset_readdata: got %h want 0", rd1); end
    @(negedge clk);
    reset_n = 1'b1;
    tick(10 + ((LAT > 0) ? LAT + 3 : 0));
    bus_read(2'd3, v1, v2);
    total++; if (v1 !== ((LAT > 0) ? 32'h1 : 32'h0)) begin bad++; $display("FAIL rearm_capture: got %h", v1); end
    bus_read(2'd2, v1, v2);
    total++; if (v1 !== 32'h0) begin bad++; $display("FAIL reset_mask_cleared: got %h want 0", v1); end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in1        = '0;
    in2        = '0;
    test_reset();
    test_rise_irq();
    test_set_clear_collision();
    test_mask();
    test_any_edge_narrow();
`ifdef PIO_IN_DEBOUNCE_EN
    test_debounce();
`endif
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
